uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx_sched.sv | 123 ++++++++++++
 tb/tb_uart_tx_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and its baud generator.
package uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE
   } uart_sched_state_e;

   // Parity disabled drives a constant 1 so uart_tx sees an idle-level bit.
   function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                        input logic                   enable,
                                        input logic                   odd);
      return enable ? ((^data) ^ odd) : 1'b1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable divider producing the one-cycle x16 oversample tick for the UART pair.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_tick;
   logic             w_wrap;

   // Using >= lets a shrinking divisor wrap on the very next cycle instead of overrunning.
   assign w_wrap = (baud_div <= DIV_W'(1)) || (r_cnt >= baud_div - DIV_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!enable) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + DIV_W'(1);
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte requesters.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DIV_W   = 16,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           tx_enable,
   input  logic                           parity_enable,
   input  logic                           parity_odd,
   input  logic [DIV_W-1:0]               baud_div,
   output logic                           tick_baud_x16,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             tx_done,
   output logic                           busy,
   output logic [ID_W-1:0]                grant_id,
   output logic                           uart_wr,
   output logic [UART_DATA_W-1:0]         uart_wr_data,
   output logic                           uart_wr_parity,
   input  logic                           uart_idle
);

   uart_sched_state_e      r_state;
   logic [ID_W-1:0]        r_ptr;
   logic [ID_W-1:0]        r_grant_id;
   logic [NUM_REQ-1:0]     r_req_ready;
   logic [NUM_REQ-1:0]     r_tx_done;
   logic                   r_uart_wr;
   logic [UART_DATA_W-1:0] r_uart_wr_data;
   logic                   r_uart_wr_parity;

   logic [ID_W-1:0]        w_pick;
   logic [UART_DATA_W-1:0] w_pick_data;
   logic                   w_any;
   logic                   w_start;

   // Scans downward so the requester closest after ptr is the last (winning) assignment.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] sel;
      int              idx;
      sel = ptr;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (valid[idx]) sel = ID_W'(idx);
      end
      return sel;
   endfunction

   uart_baud_gen #(
      .DIV_W(DIV_W)
   ) u_baud_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable  (tx_enable),
      .baud_div(baud_div),
      .tick    (tick_baud_x16)
   );

   assign w_any       = |req_valid;
   assign w_pick      = rr_pick(req_valid, r_ptr);
   assign w_pick_data = req_data[int'(w_pick)*UART_DATA_W +: UART_DATA_W];
   assign w_start     = tx_enable && uart_idle && w_any;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= IDLE;
         r_ptr            <= ID_W'(NUM_REQ - 1);
         r_grant_id       <= '0;
         r_req_ready      <= '0;
         r_tx_done        <= '0;
         r_uart_wr        <= 1'b0;
         r_uart_wr_data   <= '0;
         r_uart_wr_parity <= 1'b0;
      end else begin
         // NOTE: strobes default low each cycle so they can only ever be one-cycle pulses.
         r_uart_wr   <= 1'b0;
         r_req_ready <= '0;
         r_tx_done   <= '0;
         if (r_state != IDLE && !tx_enable) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_start) begin
                     r_grant_id       <= w_pick;
                     r_ptr            <= w_pick;
                     r_uart_wr_data   <= w_pick_data;
                     r_uart_wr_parity <= calc_parity(w_pick_data, parity_enable, parity_odd);
                     r_uart_wr        <= 1'b1;
                     r_req_ready      <= NUM_REQ'(1) << w_pick;
                     r_state          <= ISSUE;
                  end
               end
               ISSUE:      r_state <= WAIT_START;
               // uart_idle still reads high for one cycle after the load strobe.
               WAIT_START: r_state <= WAIT_DONE;
               WAIT_DONE: begin
                  if (uart_idle) begin
                     r_tx_done <= NUM_REQ'(1) << r_grant_id;
                     r_state   <= IDLE;
                  end
               end
               default:    r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy           = (r_state != IDLE);
   assign grant_id       = r_grant_id;
   assign req_ready      = r_req_ready;
   assign tx_done        = r_tx_done;
   assign uart_wr        = r_uart_wr;
   assign uart_wr_data   = r_uart_wr_data;
   assign uart_wr_parity = r_uart_wr_parity;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural uart_tx idle model.
module tb_uart_tx_sched;

   localparam int NUM_REQ = 4;
   localparam int DIV_W   = 16;
   localparam int ID_W    = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 tx_enable = 1'b0;
   logic                 parity_enable = 1'b0;
   logic                 parity_odd = 1'b0;
   logic [DIV_W-1:0]     baud_div = '0;
   logic                 tick_baud_x16;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ*8-1:0] req_data = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   tx_done;
   logic                 busy;
   logic [ID_W-1:0]      grant_id;
   logic                 uart_wr;
   logic [7:0]           uart_wr_data;
   logic                 uart_wr_parity;
   logic                 uart_idle;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       par;
   } exp_t;

   exp_t               sb[$];
   logic [7:0]         req_q[NUM_REQ][$];
   int                 n_cmp = 0;
   int                 n_bad = 0;
   int                 cyc = 0;
   int                 last_wr_cyc = 0;
   int                 last_done_cyc = 0;
   int                 n_done = 0;
   logic [NUM_REQ-1:0] last_done_vec = '0;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .NUM_REQ(NUM_REQ),
      .DIV_W  (DIV_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .tx_enable     (tx_enable),
      .parity_enable (parity_enable),
      .parity_odd    (parity_odd),
      .baud_div      (baud_div),
      .tick_baud_x16 (tick_baud_x16),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_done       (tx_done),
      .busy          (busy),
      .grant_id      (grant_id),
      .uart_wr       (uart_wr),
      .uart_wr_data  (uart_wr_data),
      .uart_wr_parity(uart_wr_parity),
      .uart_idle     (uart_idle)
   );

   // uart_tx stand-in: idle drops the cycle after wr and stays low for bits*16*div clocks.
   logic m_idle;
   int   m_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle <= 1'b1;
         m_cnt  <= 0;
      end else if (!tx_enable) begin
         m_idle <= 1'b1;
         m_cnt  <= 0;
      end else if (uart_wr) begin
         m_idle <= 1'b0;
         m_cnt  <= (parity_enable ? 11 : 10) * 16 * ((baud_div < 2) ? 1 : int'(baud_div));
      end else if (!m_idle) begin
         if (m_cnt <= 1) m_idle <= 1'b1;
         else            m_cnt  <= m_cnt - 1;
      end
   end
   assign uart_idle = m_idle;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got cyc=%0d want finish", cyc);
      $fatal(1);
   end

   function automatic logic exp_par(input logic [7:0] d);
      return parity_enable ? ((^d) ^ parity_odd) : 1'b1;
   endfunction

   task automatic refresh_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (req_q[i].size() > 0);
         if (req_q[i].size() > 0) req_data[8*i +: 8] = req_q[i][0];
      end
   endtask

   task automatic send(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      e.par  = exp_par(d);
      req_q[id].push_back(d);
      sb.push_back(e);
      refresh_reqs();
   endtask

   // One clock: sample at negedge, pop the scoreboard on uart_wr, service requesters.
   task automatic cycle();
      exp_t               e;
      logic [NUM_REQ-1:0] oh;
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (uart_wr) begin
            last_wr_cyc = cyc;
            n_cmp++;
            if (uart_idle !== 1'b1) begin
               n_bad++;
               $display("FAIL wr_while_busy: got uart_idle=%b want 1 at cyc %0d", uart_idle, cyc);
            end
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_wr: got wr id=%0d data=%h want none", grant_id, uart_wr_data);
            end else begin
               e  = sb.pop_front();
               oh = NUM_REQ'(1) << e.id;
               if ({grant_id, uart_wr_data, uart_wr_parity, req_ready} !==
                   {ID_W'(e.id), e.data, e.par, oh}) begin
                  n_bad++;
                  $display("FAIL wr_fields: got id=%0d data=%h par=%b ready=%b, want id=%0d data=%h par=%b ready=%b",
                           grant_id, uart_wr_data, uart_wr_parity, req_ready, e.id, e.data, e.par, oh);
               end
            end
         end else if (req_ready !== '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_without_wr: got req_ready=%b want 0000", req_ready);
         end
         if (tx_done !== '0) begin
            last_done_cyc = cyc;
            last_done_vec = tx_done;
            n_done++;
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
         refresh_reqs();
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_sb_empty(input int budget, input string name);
      int n = 0;
      while (sb.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL %s: got %0d frames not issued want 0", name, sb.size());
      end
   endtask

   task automatic wait_done(input int id, input int exp_cyc, input string name);
      int start = n_done;
      int n     = 0;
      while (n_done == start && n < 3000) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (n_done == start) begin
         n_bad++;
         $display("FAIL %s: got no tx_done want tx_done[%0d] at cyc %0d", name, id, exp_cyc);
      end else if (last_done_vec !== (NUM_REQ'(1) << id) || last_done_cyc != exp_cyc) begin
         n_bad++;
         $display("FAIL %s: got tx_done=%b at cyc %0d want %b at cyc %0d",
                  name, last_done_vec, last_done_cyc, NUM_REQ'(1) << id, exp_cyc);
      end
   endtask

   task automatic wait_tick(output int t, input string name);
      int n = 0;
      cycle();
      while (tick_baud_x16 !== 1'b1 && n < 50) begin
         cycle();
         n++;
      end
      t = cyc;
      if (tick_baud_x16 !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no tick want tick within 50 cycles", name);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_cmp++;
      if ({tick_baud_x16, req_ready, tx_done, busy, grant_id, uart_wr, uart_wr_data, uart_wr_parity} !== '0) begin
         n_bad++;
         $display("FAIL %s: got tick=%b ready=%b done=%b busy=%b id=%0d wr=%b data=%h par=%b want all 0",
                  name, tick_baud_x16, req_ready, tx_done, busy, grant_id, uart_wr, uart_wr_data, uart_wr_parity);
      end
   endtask

   task automatic test_reset();
      #1;
      check_all_zero("reset_hold");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle();
      check_all_zero("reset_release");
   endtask

   task automatic test_round_robin();
      int start;
      baud_div      = 16'd4;
      parity_enable = 1'b1;
      parity_odd    = 1'b0;
      tx_enable     = 1'b1;
      start         = n_done;
      send(0, 8'h10);
      send(1, 8'h21);
      send(2, 8'h32);
      send(3, 8'h47);
      send(0, 8'hF0);
      wait_sb_empty(5000, "rr_issue");
      for (int i = 0; i < 1000 && n_done < start + 5; i++) cycle();
      n_cmp++;
      if (n_done != start + 5 || last_done_vec !== 4'b0001) begin
         n_bad++;
         $display("FAIL rr_done: got %0d done, last=%b want 5 done, last=0001", n_done - start, last_done_vec);
      end
   endtask

   task automatic test_single();
      int v;
      parity_enable = 1'b1;
      parity_odd    = 1'b0;
      send(0, 8'hA5);
      v = cyc;
      wait_sb_empty(10, "single_issue");
      n_cmp++;
      if (last_wr_cyc != v + 1) begin
         n_bad++;
         $display("FAIL single_latency: got wr at cyc %0d want %0d", last_wr_cyc, v + 1);
      end
      cycle();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single_busy: got busy=%b want 1", busy);
      end
      wait_done(0, v + 704 + 3, "single_done");
   endtask

   task automatic test_parity();
      int v;
      parity_enable = 1'b1;
      parity_odd    = 1'b1;
      send(1, 8'h01);
      v = cyc;
      wait_done(1, v + 704 + 3, "odd_parity_done");
      parity_enable = 1'b0;
      send(1, 8'h01);
      v = cyc;
      wait_done(1, v + 640 + 3, "no_parity_done");
   endtask

   task automatic test_baud();
      int t0, t1, t2, t3, t4;
      baud_div = 16'd5;
      wait_tick(t0, "baud5_a");
      wait_tick(t1, "baud5_b");
      wait_tick(t2, "baud5_c");
      n_cmp++;
      if (t1 - t0 != 5 || t2 - t1 != 5) begin
         n_bad++;
         $display("FAIL baud5_period: got %0d,%0d want 5,5", t1 - t0, t2 - t1);
      end
      run(3);
      baud_div = 16'd2;
      wait_tick(t3, "baud2_a");
      wait_tick(t4, "baud2_b");
      n_cmp++;
      if (t3 != t2 + 4 || t4 != t3 + 2) begin
         n_bad++;
         $display("FAIL baud_switch: got ticks at +%0d,+%0d want +4,+6", t3 - t2, t4 - t2);
      end
      baud_div = 16'd0;
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_cmp++;
         if (tick_baud_x16 !== 1'b1) begin
            n_bad++;
            $display("FAIL baud0_every_cycle: got tick=%b want 1", tick_baud_x16);
         end
      end
      tx_enable = 1'b0;
      run(2);
      n_cmp++;
      if (tick_baud_x16 !== 1'b0) begin
         n_bad++;
         $display("FAIL baud_disabled: got tick=%b want 0", tick_baud_x16);
      end
      baud_div  = 16'd4;
      tx_enable = 1'b1;
   endtask

   task automatic test_abort();
      int v, d0;
      parity_enable = 1'b1;
      parity_odd    = 1'b0;
      send(3, 8'h3C);
      wait_sb_empty(10, "abort_issue");
      run(20);
      tx_enable = 1'b0;
      cycle();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_busy: got busy=%b want 0", busy);
      end
      d0 = n_done;
      run(800);
      n_cmp++;
      if (n_done != d0) begin
         n_bad++;
         $display("FAIL abort_no_done: got %0d tx_done pulses want 0", n_done - d0);
      end
      tx_enable = 1'b1;
      send(2, 8'h5A);
      v = cyc;
      wait_done(2, v + 704 + 3, "abort_recover_done");
   endtask

   task automatic test_reset_midframe();
      int v;
      baud_div      = 16'd1;
      parity_enable = 1'b1;
      parity_odd    = 1'b0;
      send(0, 8'h81);
      wait_sb_empty(10, "rst_mid_issue");
      run(30);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid_async");
      sb.delete();
      for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
      refresh_reqs();
      run(2);
      rst = 1'b0;
      send(0, 8'h11);
      send(2, 8'h22);
      v = cyc;
      wait_done(0, v + 176 + 3, "rst_first_grant");
      v = last_done_cyc;
      wait_done(2, v + 176 + 3, "rst_second_grant");
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_parity();
      test_baud();
      test_abort();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
